// File: rtl/jk_seq_driver_pkg.sv
// jk_seq_pkg: shared FSM states, counter width and the JK excitation function.
package jk_seq_pkg;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
  // Returns {j,k}; don't-cares resolve to 0, flips use J=K=1 in toggle mode.
  function automatic logic [1:0] excite(input logic q_bit, input logic t_bit, input logic toggle_mode);
    return toggle_mode ? {2{q_bit ^ t_bit}} : {~q_bit & t_bit, q_bit & ~t_bit};
  endfunction
endpackage

// File: rtl/jk_seq_driver_if.sv
// jk_seq_driver_if: valid/ready target-word handshake into the sequencer.
interface jk_seq_driver_if #(parameter int WIDTH = 4);
  logic tgt_valid;
  logic [WIDTH-1:0] tgt_data;
  logic tgt_ready;
  modport master(output tgt_valid, tgt_data, input tgt_ready);
  modport slave(input tgt_valid, tgt_data, output tgt_ready);
endinterface

// File: rtl/jk_seq_driver_jk_reg.sv
// jk_reg: WIDTH-bit bank of JK flip-flops with synchronous clear and clock enable.
module jk_reg #(parameter int WIDTH = 4) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (clr) q <= '0;
    else if (en) q <= (j & ~q) | (~k & q);
endmodule

// File: rtl/jk_seq_driver.sv
// jk_seq_driver: queues target words and drives a JK bank to each in turn; JK_TOGGLE_EN selects toggle excitation.
module jk_seq_driver
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  jk_seq_driver_if.slave   tgt,
  input  logic             frz,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             done,
  output logic             match,
  output logic [CNT_W-1:0] step_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int AW = $clog2(DEPTH);
`ifdef JK_TOGGLE_EN
  localparam logic TOGGLE = 1'b1;
`else
  localparam logic TOGGLE = 1'b0;
`endif
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [WIDTH-1:0] head, tgt_reg, nj, nk;
  logic push, pop;
  state_t state;
  assign head = mem[rd_ptr];
  assign tgt.tgt_ready = count != (AW+1)'(DEPTH);
  assign push = tgt.tgt_valid & tgt.tgt_ready;
  assign pop = (state == IDLE) && (count != '0);
  assign match = done && (q == tgt_reg);
  for (genvar i = 0; i < WIDTH; i++) begin : g_exc
    assign {nj[i], nk[i]} = excite(q[i], head[i], TOGGLE);
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tgt.tgt_data;
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // done is registered on the DRIVE->CHECK edge so it lines up with the updated q.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      j <= '0;
      k <= '0;
      done <= 1'b0;
      tgt_reg <= '0;
      step_cnt <= '0;
      err_cnt <= '0;
    end else begin
      done <= state == DRIVE;
      unique case (state)
        IDLE: if (pop) begin
          tgt_reg <= head;
          j <= nj;
          k <= nk;
          state <= DRIVE;
        end
        DRIVE: begin
          j <= '0;
          k <= '0;
          state <= CHECK;
        end
        CHECK: begin
          step_cnt <= step_cnt + 1'b1;
          if (!match && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  jk_reg #(.WIDTH(WIDTH)) u_bank (.clk(clk), .clr(clr), .en(!frz), .j(j), .k(k), .q(q));
endmodule

// File: tb/tb_jk_seq_driver.sv
// tb_jk_seq_driver: directed vector table plus multi-cycle corner sequences for jk_seq_driver.
module tb_jk_seq_driver;
  logic clk = 1'b0;
  logic clr, frz;
  logic [3:0] j, k, q;
  logic done, match;
  logic [7:0] step_cnt, err_cnt;
  int checks = 0, errors = 0;
  logic [7:0] step_exp = 8'd0, err_exp = 8'd0;
  logic [3:0] q_exp;
  logic saw_full = 1'b0;
  int cyc = 0;
  typedef struct {
    logic [3:0] tgt;
    logic frz;
    logic [3:0] j, k, q;
    logic m;
  } vec_t;
  vec_t tbl[9];
  jk_seq_driver_if #(.WIDTH(4)) tif();
  jk_seq_driver #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .clr(clr), .tgt(tif.slave), .frz(frz), .j(j), .k(k), .q(q),
    .done(done), .match(match), .step_cnt(step_cnt), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [3:0] d);
    int n = 0;
    @(negedge clk);
    tif.tgt_valid = 1'b1;
    tif.tgt_data = d;
    while (!tif.tgt_ready && n < 50) begin
      saw_full = 1'b1;
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push_timeout", 0, 1);
    @(posedge clk);
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 30);
    if (!done) chk({name, "_timeout"}, 0, 1);
  endtask
  initial begin
    logic [3:0] bb[7];
    logic [3:0] ej, ek;
    int last;
    logic seen;
    tbl[0] = '{4'b1010, 1'b0, 4'b1010, 4'b0000, 4'b1010, 1'b1};
    tbl[1] = '{4'b0110, 1'b0, 4'b0100, 4'b1000, 4'b0110, 1'b1};
    tbl[2] = '{4'b0101, 1'b0, 4'b0001, 4'b0010, 4'b0101, 1'b1};
    tbl[3] = '{4'b1111, 1'b0, 4'b1010, 4'b0000, 4'b1111, 1'b1};
    tbl[4] = '{4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b1};
    tbl[5] = '{4'b0000, 1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b1};
    tbl[6] = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0};
    tbl[7] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    tbl[8] = '{4'b1001, 1'b0, 4'b1001, 4'b0000, 4'b1001, 1'b1};
    bb = '{4'b1010, 4'b0101, 4'b1111, 4'b0000, 4'b0110, 4'b1001, 4'b0011};
    // Reset with a word offered: it must not be taken.
    clr = 1'b1;
    frz = 1'b0;
    tif.tgt_valid = 1'b1;
    tif.tgt_data = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_j", j, 0);
    chk("rst_k", k, 0);
    chk("rst_done", done, 0);
    chk("rst_match", match, 0);
    chk("rst_ready", tif.tgt_ready, 1);
    chk("rst_step", step_cnt, 0);
    chk("rst_err", err_cnt, 0);
    clr = 1'b0;
    tif.tgt_valid = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("rst_no_accept_done", seen, 0);
    chk("rst_no_accept_q", q, 0);
    chk("rst_no_accept_step", step_cnt, 0);
    // Single-target vectors, each run to completion.
    foreach (tbl[v]) begin
`ifdef JK_TOGGLE_EN
      ej = tbl[v].j | tbl[v].k;
      ek = tbl[v].j | tbl[v].k;
`else
      ej = tbl[v].j;
      ek = tbl[v].k;
`endif
      push(tbl[v].tgt);
      @(negedge clk);
      tif.tgt_valid = 1'b0;
      frz = tbl[v].frz;
      @(negedge clk);
      chk($sformatf("v%0d_j", v), j, ej);
      chk($sformatf("v%0d_k", v), k, ek);
      @(negedge clk);
      chk($sformatf("v%0d_done", v), done, 1);
      chk($sformatf("v%0d_match", v), match, tbl[v].m);
      chk($sformatf("v%0d_q", v), q, tbl[v].q);
      step_exp++;
      if (!tbl[v].m) err_exp++;
      @(negedge clk);
      chk($sformatf("v%0d_done_off", v), done, 0);
      chk($sformatf("v%0d_step", v), step_cnt, step_exp);
      chk($sformatf("v%0d_err", v), err_cnt, err_exp);
    end
    // Back-to-back stream that overfills the FIFO.
    frz = 1'b0;
    fork
      begin
        foreach (bb[w]) push(bb[w]);
        @(negedge clk);
        tif.tgt_valid = 1'b0;
      end
      begin
        last = 0;
        foreach (bb[w]) begin
          wait_done($sformatf("bb%0d", w));
          chk($sformatf("bb%0d_match", w), match, 1);
          chk($sformatf("bb%0d_q", w), q, bb[w]);
          if (w > 0) chk($sformatf("bb%0d_gap", w), cyc - last, 3);
          last = cyc;
          step_exp++;
        end
      end
    join
    @(negedge clk);
    chk("bb_saw_full", saw_full, 1);
    chk("bb_step", step_cnt, step_exp);
    chk("bb_err", err_cnt, err_exp);
    q_exp = 4'b0011;
    // Frozen bank: every target mismatches until err_cnt saturates, step_cnt wraps.
    frz = 1'b1;
    while (err_exp != 8'd255) begin
      push(q_exp ^ 4'b0001);
      @(negedge clk);
      tif.tgt_valid = 1'b0;
      wait_done("sat");
      step_exp++;
      err_exp++;
    end
    @(negedge clk);
    chk("sat_err", err_cnt, 255);
    chk("sat_step_wrap", step_cnt, step_exp);
    chk("sat_q_held", q, q_exp);
    push(q_exp ^ 4'b0001);
    @(negedge clk);
    tif.tgt_valid = 1'b0;
    wait_done("sat_extra");
    chk("sat_extra_match", match, 0);
    step_exp++;
    @(negedge clk);
    chk("sat_extra_err", err_cnt, 255);
    chk("sat_extra_step", step_cnt, step_exp);
    // clr while driving the second word with two more still queued.
    frz = 1'b0;
    push(4'b0000);
    push(4'b1100);
    push(4'b0110);
    push(4'b0011);
    @(negedge clk);
    tif.tgt_valid = 1'b0;
    @(negedge clk);
    chk("clr_drive_j", j, 4'b1100);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_done", done, 0);
    chk("clr_q", q, 0);
    chk("clr_j", j, 0);
    chk("clr_ready", tif.tgt_ready, 1);
    chk("clr_step", step_cnt, 0);
    chk("clr_err", err_cnt, 0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("clr_fifo_empty", seen, 0);
    push(4'b0011);
    @(negedge clk);
    tif.tgt_valid = 1'b0;
    wait_done("post_clr");
    chk("post_clr_match", match, 1);
    chk("post_clr_q", q, 4'b0011);
    @(negedge clk);
    chk("post_clr_step", step_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jk_seq_driver.md
# jk_seq_driver

Sequencer that drives a bank of JK flip-flops through a queue of requested target states. It accepts WIDTH-bit target words over a valid/ready handshake and buffers them in a small FIFO. For each word it derives the JK excitation from the current and target state, applies it for one clock, then checks that the bank reached the target. It sits upstream of the JK storage cells and turns "desired state" into "J/K inputs", the inverse of a JK flop's characteristic equation.

## Interface
- WIDTH, 4, number of JK cells in the bank
- DEPTH, 4, target FIFO depth in entries (power of two, ≥2)
- clk  in  1  sole clock; all state updates on its rising edge
- clr  in  1  reset, synchronous, active-high
- tgt_valid  in  1  target word offered
- tgt_data  in  WIDTH  requested next state of the bank
- tgt_ready  out  1  FIFO can accept; equals !full
- frz  in  1  freezes the JK bank (clock-enable low); sampled in DRIVE
- j  out  WIDTH  registered J inputs presented to the bank
- k  out  WIDTH  registered K inputs presented to the bank
- q  out  WIDTH  current bank state
- done  out  1  one-cycle pulse; a target has been checked
- match  out  1  valid with done; q equalled the target
- step_cnt  out  8  checked targets, wraps 255→0
- err_cnt  out  8  mismatches, saturates at 255

## Operation
- Handshake: a word is written when tgt_valid && tgt_ready at a rising edge. tgt_data must stay stable while tgt_valid is high and tgt_ready is low.
- FSM states:
  - IDLE: FIFO non-empty → pop head, latch it into tgt_reg, register j/k excitation from (q, head), go to DRIVE. Otherwise stay.
  - DRIVE: bank samples j/k at the end of this cycle unless frz=1. j/k are cleared at the same edge. Go to CHECK.
  - CHECK: done=1, match=(q==tgt_reg), step_cnt+1, err_cnt+1 if !match and not yet saturated. Go to IDLE.
- Excitation per bit, default:
  - 0→0: J=0, K=0
  - 0→1: J=1, K=0
  - 1→0: J=0, K=1
  - 1→1: J=0, K=0
  - Don't-cares are resolved to 0.
- JK bank: J=K=0 hold, J=1 K=0 set, J=0 K=1 reset, J=K=1 toggle.
- Full FIFO: tgt_ready=0 and offered words are not accepted. A pop in the same cycle frees a slot for the next cycle only; there is no same-cycle push-through.
- Empty FIFO: FSM idles with j=k=0 and the bank holds.
- Pointers wrap modulo DEPTH. Occupancy counter has width clog2(DEPTH)+1.
- Reset mid-operation: clr overrides every other input in that cycle. FIFO is emptied, the in-flight target is discarded, no done pulse is produced, and the FSM returns to IDLE.

## Timing
- Reset values (after a clr edge): q=0, j=0, k=0, done=0, match=0, step_cnt=0, err_cnt=0, tgt_ready=1, FSM=IDLE, FIFO empty.
- Word accepted at edge E0: IDLE pops at E1 and j/k are valid in cycle E1–E2.
- q updates at E2. done and match are high in cycle E2–E3 and counters are updated at E3.
- Per-target latency is 3 cycles from acceptance to the end of the done pulse. Sustained throughput is one target per 3 cycles.
- frz only matters during DRIVE. Asserted then, q holds and the CHECK reports match=0 unless the target equalled the old q.

## Configuration
- JK_TOGGLE_EN defined: a bit that must flip uses J=K=1 (toggle) instead of set/reset. q trajectories are identical; only the j/k encodings differ (0→1 and 1→0 both give j=1, k=1).
- JK_TOGGLE_EN undefined: set/reset encoding as listed above, and J=K=1 is never driven.

## Structure
- Package jk_seq_pkg holds:
  - state enum (IDLE, DRIVE, CHECK)
  - excitation function excite(q_bit, t_bit, toggle_mode) returning {j,k}
  - counter width constant CNT_W=8
- Sub-module jk_reg: WIDTH-bit JK bank with synchronous clr and enable (driven by !frz). It is instantiated once; q is its output.
- FIFO, FSM and counters live in the top module.

## Test plan
- Reset: clr high for 2 cycles → q=0, j=k=0, tgt_ready=1, step_cnt=err_cnt=0; a word offered during clr is not accepted.
- Single target 4'b1010 from q=0 → DRIVE shows j=1010, k=0000; q=1010 at E2; done=1, match=1, step_cnt=1.
- Sequence 1010, 0101, 1111, 0000 back-to-back → tgt_ready drops when 4 are queued; four done pulses 3 cycles apart, all match.
- JK_TOGGLE_EN build, q=1010 → target 0110 → j=k=1100, q=0110, match=1.
- frz=1 during DRIVE for target 0001 from q=0 → q stays 0000, match=0, err_cnt=1; drive err_cnt to 255 and apply one more mismatch → stays 255.
- clr in DRIVE with 2 words queued → no done pulse, FIFO empty, q=0; a new word is then processed normally.
